// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, branch condition codes and the execute-stage entry record.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_AW = 3;
  localparam int unsigned PC_W   = 16;

  typedef enum logic [1:0] {
    BR_EQ = 2'b00,
    BR_NE = 2'b01,
    BR_LT = 2'b10,
    BR_GE = 2'b11
  } br_cond_e;

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_ONE   = 2'd1,
    SLOT_FULL  = 2'd2
  } slot_cnt_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              lt;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic              set_flags;
    logic              br_en;
    br_cond_e          br_cond;
    logic [PC_W-1:0]   br_target;
  } ex_entry_t;

  function automatic logic br_cond_met(input br_cond_e cond, input logic z, input logic n);
    logic met;
    unique case (cond)
      BR_EQ:   met = z;
      BR_NE:   met = ~z;
      BR_LT:   met = n;
      BR_GE:   met = ~n;
      default: met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/ex_skid_buffer.sv
// Two-entry FIFO of executed instructions; slot0 is always the head.
module ex_skid_buffer
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  ex_entry_t push_data,
  input  logic      pop,
  input  logic      flush,
  output slot_cnt_e count,
  output ex_entry_t head,
  output logic      head_valid
);

  slot_cnt_e cnt_q, cnt_d;
  ex_entry_t slot0, slot1;
  logic      wr0, wr1;

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = SLOT_EMPTY;
    end else begin
      unique case ({push, pop})
        2'b10:   cnt_d = (cnt_q == SLOT_EMPTY) ? SLOT_ONE : SLOT_FULL;
        2'b01:   cnt_d = (cnt_q == SLOT_FULL) ? SLOT_ONE : SLOT_EMPTY;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pushed data lands in whichever slot is the tail after any pop this cycle.
  always_comb begin
    wr0 = push & ((cnt_q == SLOT_EMPTY) | (pop & (cnt_q == SLOT_ONE)));
    wr1 = push & (((cnt_q == SLOT_ONE) & ~pop) | ((cnt_q == SLOT_FULL) & pop));
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt_q <= SLOT_EMPTY;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      cnt_q <= cnt_d;
      slot0 <= wr0 ? push_data : (pop ? slot1 : slot0);
      slot1 <= wr1 ? push_data : (pop ? ex_entry_t'('0) : slot1);
    end
  end

  assign count      = cnt_q;
  assign head       = slot0;
  assign head_valid = (cnt_q != SLOT_EMPTY);

endmodule

// File: rtl/ex_retire_stage.sv
// Execute-retire stage: buffers ALU results, drives register writeback, keeps Z/N flags
// and resolves conditional branches into a one-cycle redirect that squashes younger work.
module ex_retire_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned PC_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_zero,
  input  logic              in_lt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wen,
  input  logic              in_set_flags,
  input  logic              in_br_en,
  input  logic [1:0]        in_br_cond,
  input  logic [PC_W-1:0]   in_br_target,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              flag_z,
  output logic              flag_n
);

  import cpu_pkg::*;

  ex_entry_t in_entry, head;
  slot_cnt_e count;
  logic      head_valid, need_wb, retire, z_eff, n_eff, taken, push;

  always_comb begin
    in_entry           = '0;
    in_entry.result    = in_result;
    in_entry.zero      = in_zero;
    in_entry.lt        = in_lt;
    in_entry.rd        = in_rd;
    in_entry.wen       = in_wen;
    in_entry.set_flags = in_set_flags;
    in_entry.br_en     = in_br_en;
    in_entry.br_cond   = br_cond_e'(in_br_cond);
    in_entry.br_target = in_br_target;
  end

  ex_skid_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (in_entry),
    .pop        (retire),
    .flush      (taken),
    .count      (count),
    .head       (head),
    .head_valid (head_valid)
  );

  // Ready depends only on the registered count, never on wb_ready.
  assign in_ready = (count != SLOT_FULL);

  // Reset suppresses retirement so a pending write or redirect is abandoned.
  always_comb begin
    need_wb = head.wen & (head.rd != '0);
    retire  = head_valid & (wb_ready | ~need_wb) & ~rst;
    z_eff   = head.set_flags ? head.zero : flag_z;
    n_eff   = head.set_flags ? head.lt : flag_n;
    taken   = retire & head.br_en & br_cond_met(head.br_cond, z_eff, n_eff);
    push    = in_valid & in_ready & ~taken;
  end

  assign wb_valid       = head_valid & need_wb & ~rst;
  assign wb_addr        = head_valid ? head.rd : '0;
  assign wb_data        = head_valid ? head.result : '0;
  assign redirect_valid = taken;
  assign redirect_pc    = head_valid ? head.br_target : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (retire && head.set_flags) begin
      flag_z <= head.zero;
      flag_n <= head.lt;
    end
  end

endmodule

// File: tb/tb_ex_retire_stage.sv
// Self-checking bench for ex_retire_stage: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_ex_retire_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_result;
  logic        in_zero, in_lt;
  logic [2:0]  in_rd;
  logic        in_wen, in_set_flags, in_br_en;
  logic [1:0]  in_br_cond;
  logic [15:0] in_br_target;
  logic        wb_valid, wb_ready;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        flag_z, flag_n;

  ex_retire_stage #(.DATA_W(16), .REG_AW(3), .PC_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_result      (in_result),
    .in_zero        (in_zero),
    .in_lt          (in_lt),
    .in_rd          (in_rd),
    .in_wen         (in_wen),
    .in_set_flags   (in_set_flags),
    .in_br_en       (in_br_en),
    .in_br_cond     (in_br_cond),
    .in_br_target   (in_br_target),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flag_z         (flag_z),
    .flag_n         (flag_n)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ex_entry_t model_q[$];
  logic      m_z = 1'b0;
  logic      m_n = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic ex_entry_t mk(input logic [15:0] res, input logic [2:0] rd, input logic wen,
                                   input logic sf, input logic br, input logic [1:0] cond,
                                   input logic [15:0] tgt);
    ex_entry_t e;
    e           = '0;
    e.result    = res;
    e.zero      = (res == 16'h0000);
    e.lt        = res[15];
    e.rd        = rd;
    e.wen       = wen;
    e.set_flags = sf;
    e.br_en     = br;
    e.br_cond   = br_cond_e'(cond);
    e.br_target = tgt;
    return e;
  endfunction

  function automatic logic cond_ok(input logic [1:0] c, input logic z, input logic n);
    case (c)
      2'd0:    return z;
      2'd1:    return !z;
      2'd2:    return n;
      default: return !n;
    endcase
  endfunction

  // One clock cycle: drive, check combinational outputs against the model, then advance the model.
  task automatic step(input logic v, input ex_entry_t e, input logic wbr, input logic r);
    ex_entry_t h;
    logic      has, rdy, need, ret, ze, ne, tk;
    @(negedge clk);
    rst          = r;
    in_valid     = v;
    in_result    = e.result;
    in_zero      = e.zero;
    in_lt        = e.lt;
    in_rd        = e.rd;
    in_wen       = e.wen;
    in_set_flags = e.set_flags;
    in_br_en     = e.br_en;
    in_br_cond   = e.br_cond;
    in_br_target = e.br_target;
    wb_ready     = wbr;
    #1;
    has  = (model_q.size() > 0);
    h    = has ? model_q[0] : ex_entry_t'('0);
    rdy  = (model_q.size() < 2);
    need = h.wen && (h.rd != 3'd0);
    ret  = has && !r && (wbr || !need);
    ze   = h.set_flags ? h.zero : m_z;
    ne   = h.set_flags ? h.lt : m_n;
    tk   = ret && h.br_en && cond_ok(h.br_cond, ze, ne);
    check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    check("wb_valid", {31'd0, wb_valid}, {31'd0, has && need && !r});
    check("wb_addr", {29'd0, wb_addr}, {29'd0, h.rd});
    check("wb_data", {16'd0, wb_data}, {16'd0, h.result});
    check("redirect_valid", {31'd0, redirect_valid}, {31'd0, tk});
    check("redirect_pc", {16'd0, redirect_pc}, {16'd0, h.br_target});
    check("flag_z", {31'd0, flag_z}, {31'd0, m_z});
    check("flag_n", {31'd0, flag_n}, {31'd0, m_n});
    @(posedge clk);
    if (r) begin
      model_q.delete();
      m_z = 1'b0;
      m_n = 1'b0;
    end else begin
      if (ret && h.set_flags) begin
        m_z = h.zero;
        m_n = h.lt;
      end
      if (tk) begin
        model_q.delete();
      end else begin
        if (ret) void'(model_q.pop_front());
        if (v && rdy) model_q.push_back(e);
      end
    end
  endtask

  initial begin
    ex_entry_t idle, e;
    ex_entry_t offer [3];
    int unsigned idx;
    idle = '0;
    rst = 1'b1; in_valid = 1'b0; wb_ready = 1'b0;
    in_result = '0; in_zero = 1'b0; in_lt = 1'b0; in_rd = '0; in_wen = 1'b0;
    in_set_flags = 1'b0; in_br_en = 1'b0; in_br_cond = '0; in_br_target = '0;
    repeat (2) @(posedge clk);

    // reset then idle
    step(1'b0, idle, 1'b1, 1'b0);
    step(1'b0, idle, 1'b0, 1'b0);

    // back-to-back stream
    step(1'b1, mk(16'h0005, 3'd1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0), 1'b1, 1'b0);
    step(1'b1, mk(16'hFFFF, 3'd2, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0), 1'b1, 1'b0);
    step(1'b1, mk(16'h1234, 3'd3, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0), 1'b1, 1'b0);
    step(1'b0, idle, 1'b1, 1'b0);
    step(1'b0, idle, 1'b1, 1'b0);

    // backpressure: hold each offer until accepted
    offer[0] = mk(16'h0005, 3'd1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
    offer[1] = mk(16'hFFFF, 3'd2, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
    offer[2] = mk(16'h1234, 3'd3, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      if (idx < 3) begin
        logic acc;
        acc = (model_q.size() < 2);
        step(1'b1, offer[idx], (c >= 4), 1'b0);
        if (acc) idx++;
      end else begin
        step(1'b0, idle, 1'b1, 1'b0);
      end
    end
    check("bp_all_accepted", idx, 3);

    // flag bypass: compare-and-branch using its own zero flag
    step(1'b1, mk(16'h0000, 3'd0, 1'b0, 1'b1, 1'b1, 2'd0, 16'h0040), 1'b1, 1'b0);
    step(1'b0, idle, 1'b1, 1'b0);
    step(1'b0, idle, 1'b1, 1'b0);

    // stored flags + squash: SUB(lt) then BLT (writes r6) with r4 queued behind it
    step(1'b1, mk(16'hFFFE, 3'd5, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0), 1'b0, 1'b0);
    step(1'b1, mk(16'h0009, 3'd6, 1'b1, 1'b0, 1'b1, 2'd2, 16'h0080), 1'b0, 1'b0);
    step(1'b0, idle, 1'b1, 1'b0);
    step(1'b1, mk(16'h4444, 3'd4, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0), 1'b0, 1'b0);
    step(1'b0, idle, 1'b1, 1'b0);
    check("squash_empty", model_q.size(), 0);
    step(1'b0, idle, 1'b0, 1'b0);
    step(1'b0, idle, 1'b1, 1'b0);

    // write to r0 retires with no wb_ready and no wb_valid
    step(1'b1, mk(16'h0077, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0), 1'b0, 1'b0);
    step(1'b0, idle, 1'b0, 1'b0);
    step(1'b0, idle, 1'b0, 1'b0);

    // reset while full and stalled
    step(1'b1, mk(16'h1111, 3'd1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0), 1'b0, 1'b0);
    step(1'b1, mk(16'h2222, 3'd2, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0), 1'b0, 1'b0);
    step(1'b0, idle, 1'b0, 1'b1);
    step(1'b0, idle, 1'b1, 1'b0);
    step(1'b0, idle, 1'b1, 1'b0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] res;
      res = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom);
      e = mk(res, 3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7),
             $urandom_range(0, 1) == 1, ($urandom_range(0, 3) == 0),
             2'($urandom_range(0, 3)), 16'($urandom));
      step($urandom_range(0, 9) < 7, e, $urandom_range(0, 9) < 6, $urandom_range(0, 99) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
